trng_postproc: RTL
==================

TRNG_POSTPROC -- requirements
Module: trng_postproc

Interface
REQ-001 Parameter FIFO_DEPTH, 4, output byte FIFO entries (power of two, 2..8).
REQ-002 Parameter RCT_CUTOFF, 8, consecutive identical raw samples that trip the health test.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  block enable (design selected).
REQ-006 raw_bit  input  1  raw entropy sample from the ring-oscillator sampler.
REQ-007 raw_valid  input  1  raw_bit is a new sample this cycle.
REQ-008 out_byte  output  8  conditioned random byte at FIFO head.
REQ-009 out_valid  output  1  out_byte holds valid data.
REQ-010 out_ready  input  1  consumer accepts out_byte.
REQ-011 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 health_fail  output  1  sticky health-test failure flag.

Function
REQ-013 A sample is accepted only when ena=1 and raw_valid=1; all other cycles leave the debias and packer state unchanged, except as stated in REQ-014.
REQ-014 ena=0 shall force the debias FSM to IDLE and discard any held first bit. The packer shall keep its partial byte, and the FIFO shall keep draining.
REQ-015 Debias FSM states: IDLE and HAVE_FIRST.
- IDLE: an accepted sample is stored and the FSM moves to HAVE_FIRST.
- HAVE_FIRST: an accepted sample returns the FSM to IDLE. If the pair differs, the first bit is emitted; pair 01 emits 0 and pair 10 emits 1. If the pair is equal, both bits are discarded.
REQ-016 The debiased bit shall be registered and presented to the packer one cycle after the completing sample.
REQ-017 The packer shifts MSB-first: byte = {shreg[6:0], bit}, with a 3-bit count from 0 to 7.
REQ-018 On the 8th bit the packer attempts a FIFO push of the full byte and clears count to 0.
REQ-019 out_valid shall assert exactly 2 rising edges after the edge that samples the raw bit completing the 8th kept pair, provided the FIFO was empty.
REQ-020 Push succeeds if fifo_level<FIFO_DEPTH, or if a pop occurs in the same cycle.
- A push with no room (full, no pop) drops the byte silently.
- fifo_level is unchanged by a simultaneous push and pop.
REQ-021 out_valid = (fifo_level != 0). A pop occurs when out_valid and out_ready are both 1. out_byte = FIFO head when valid, 8'h00 when empty.
REQ-022 Pointers wrap modulo FIFO_DEPTH, and bytes exit in push order.

Reset
REQ-023 Asserting rst_n=0 shall immediately clear, regardless of clk:
- debias FSM to IDLE;
- held bit, shreg, count, FIFO pointers and fifo_level;
- the repetition counter and health_fail.
Consequently out_valid=0, out_byte=8'h00 and fifo_level=0.
REQ-024 Reset asserted mid-byte or mid-pair shall discard all partial and buffered data.
REQ-025 Reset deassertion shall be synchronised to clk with a 2-flop synchroniser before use.

Configuration
REQ-026 With macro TRNG_HEALTH_EN defined, a repetition-count test runs on accepted raw samples.
- A counter increments while each sample equals the previous one, and reloads to 1 when the sample differs.
- Reaching RCT_CUTOFF sets health_fail on that edge; health_fail stays set until reset.
- While health_fail=1 all FIFO pushes are blocked, and the FIFO still drains.
REQ-027 Without TRNG_HEALTH_EN, no counter is built, health_fail is tied to 0, and pushes are never blocked.

Structure
REQ-028 Package trng_pkg shall hold the debias state enum (IDLE, HAVE_FIRST), the default FIFO_DEPTH and RCT_CUTOFF constants, and the byte width 8.
REQ-029 The debias FSM shall be a sub-module trng_vn_debias, with ports clk, rst_n, ena, raw_bit, raw_valid, db_bit and db_valid. The packer, FIFO and health test shall remain in trng_postproc.

Verification
REQ-030 Pair stream 01,10 repeated 4 times (16 valid samples) -> out_byte=8'h55, with out_valid high 2 edges after the 16th sample.
REQ-031 Pair stream 00,11 repeated 20 times -> out_valid stays 0 and fifo_level=0.
REQ-032 out_ready=0 while bytes 8'h01..8'h05 are generated -> fifo_level=4, byte 8'h05 is dropped, and draining yields 01,02,03,04.
REQ-033 FIFO full with a new push in the same cycle as a pop -> fifo_level stays 4, and the new byte appears after 03,04.
REQ-034 TRNG_HEALTH_EN defined with eight consecutive raw 1s -> health_fail=1 on the 8th sample's edge and no further bytes are pushed; without the macro, health_fail stays 0.
REQ-035 rst_n pulsed low mid-byte with 2 bytes buffered -> out_valid=0 and fifo_level=0 immediately, and the next byte needs a full 8 new kept pairs.

Source files
------------

// File: rtl/trng_pkg.sv
// trng_pkg -- shared definitions for the TRNG post-processor.
//   db_state_e        : von Neumann debias FSM states
//   TRNG_FIFO_DEPTH   : default output FIFO depth (bytes)
//   TRNG_RCT_CUTOFF   : default repetition-count cutoff
//   TRNG_BYTE_W       : conditioned output width
package trng_pkg;

  localparam int TRNG_FIFO_DEPTH = 4;
  localparam int TRNG_RCT_CUTOFF = 8;
  localparam int TRNG_BYTE_W     = 8;

  typedef enum logic {
    IDLE       = 1'b0,
    HAVE_FIRST = 1'b1
  } db_state_e;

endpackage

// File: rtl/trng_vn_debias.sv
// trng_vn_debias -- von Neumann debiaser for the raw sampler stream.
//
//   state      | meaning
//   -----------+---------------------------------------------------
//   IDLE       | no sample held; next accepted sample is stored
//   HAVE_FIRST | first bit of a pair held; next accepted sample
//              | completes the pair (01 -> 0, 10 -> 1, 00/11 drop)
//
// Ports:
//   clk, rst_n   clock and async active-low reset
//   ena          block enable; low forces IDLE and drops the held bit
//   raw_bit      raw entropy sample
//   raw_valid    raw_bit is a new sample this cycle
//   db_bit       debiased bit (registered)
//   db_valid     one-cycle strobe, db_bit is new
module trng_vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw_bit,
  input  logic raw_valid,
  output logic db_bit,
  output logic db_valid
);

  db_state_e state_q, state_d;
  logic      first_q, first_d;
  logic      db_bit_q, db_bit_d;
  logic      db_valid_q, db_valid_d;

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    db_bit_d   = db_bit_q;
    db_valid_d = 1'b0;
    if (!ena) begin
      state_d = IDLE;
      first_d = 1'b0;
    end else if (raw_valid) begin
      case (state_q)
        IDLE: begin
          first_d = raw_bit;
          state_d = HAVE_FIRST;
        end
        HAVE_FIRST: begin
          state_d = IDLE;
          first_d = 1'b0;
          if (raw_bit != first_q) begin
            db_valid_d = 1'b1;
            db_bit_d   = first_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      first_q    <= 1'b0;
      db_bit_q   <= 1'b0;
      db_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      db_bit_q   <= db_bit_d;
      db_valid_q <= db_valid_d;
    end
  end

  assign db_bit   = db_bit_q;
  assign db_valid = db_valid_q;

endmodule

// File: rtl/trng_postproc.sv
// trng_postproc -- TRNG post-processing: von Neumann debias, MSB-first
// byte packer, output byte FIFO and optional repetition-count health test.
//
// Optional feature: define TRNG_HEALTH_EN to build the repetition-count
// test; otherwise health_fail is tied low and pushes are never blocked.
//
// Ports:
//   clk          single clock
//   rst_n        async active-low reset (deassertion synchronised internally)
//   ena          block enable
//   raw_bit      raw entropy sample
//   raw_valid    raw_bit is a new sample
//   out_byte     FIFO head (8'h00 when empty)
//   out_valid    FIFO not empty
//   out_ready    consumer accepts out_byte
//   fifo_level   FIFO occupancy
//   health_fail  sticky health-test failure
module trng_postproc
  import trng_pkg::*;
#(
  parameter int FIFO_DEPTH = TRNG_FIFO_DEPTH,
  parameter int RCT_CUTOFF = TRNG_RCT_CUTOFF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          raw_bit,
  input  logic                          raw_valid,
  output logic [TRNG_BYTE_W-1:0]        out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          health_fail
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // An out-of-range parameter set leaves the FIFO permanently empty
  // rather than building a mis-sized buffer.
  localparam bit CFG_OK = (FIFO_DEPTH >= 2) && (FIFO_DEPTH <= 8) &&
                          ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
                          (RCT_CUTOFF >= 2);

  // Reset asserts asynchronously, releases two clk edges later.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  logic db_bit, db_valid;

  trng_vn_debias u_debias (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .ena       (ena),
    .raw_bit   (raw_bit),
    .raw_valid (raw_valid),
    .db_bit    (db_bit),
    .db_valid  (db_valid)
  );

  // Packer: the completed byte is registered and written to the FIFO on
  // the following edge.
  logic [6:0]             shreg_q, shreg_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   push_q, push_d;
  logic [TRNG_BYTE_W-1:0] push_byte_q, push_byte_d;

  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    if (db_valid) begin
      shreg_d = {shreg_q[5:0], db_bit};
      if (cnt_q == 3'd7) begin
        push_d      = 1'b1;
        push_byte_d = {shreg_q, db_bit};
        cnt_d       = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
    end else begin
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
    end
  end

  // Health test
`ifdef TRNG_HEALTH_EN
  localparam int RCT_W = $clog2(RCT_CUTOFF + 1);

  logic [RCT_W-1:0] rct_cnt_q, rct_cnt_d;
  logic             rct_prev_q, rct_prev_d;
  logic             health_fail_q, health_fail_d;

  always_comb begin
    rct_cnt_d     = rct_cnt_q;
    rct_prev_d    = rct_prev_q;
    health_fail_d = health_fail_q;
    if (ena && raw_valid) begin
      // A zero count means no sample seen since reset.
      if ((rct_cnt_q == '0) || (raw_bit != rct_prev_q))
        rct_cnt_d = RCT_W'(1);
      else if (rct_cnt_q != RCT_W'(RCT_CUTOFF))
        rct_cnt_d = rct_cnt_q + RCT_W'(1);
      rct_prev_d = raw_bit;
      if (rct_cnt_d == RCT_W'(RCT_CUTOFF))
        health_fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rct_cnt_q     <= '0;
      rct_prev_q    <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      rct_cnt_q     <= rct_cnt_d;
      rct_prev_q    <= rct_prev_d;
      health_fail_q <= health_fail_d;
    end
  end

  assign health_fail = health_fail_q;
`else
  assign health_fail = 1'b0;
`endif

  // Output FIFO
  logic [TRNG_BYTE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   pop, push_ok;

  assign pop     = (level_q != '0) && out_ready;
  assign push_ok = CFG_OK && push_q && !health_fail &&
                   ((level_q < LVL_W'(FIFO_DEPTH)) || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: contents are only visible while level_q != 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_byte_q;
  end

  assign out_valid  = (level_q != '0);
  assign out_byte   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;

endmodule
